fifo_prog: RTL and testbench

FIFO_PROG -- requirements
Module: fifo_prog

---
 rtl/fifo_prog.sv | 135 +++++++++++++
 tb/tb_fifo_prog.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_prog.sv
// fifo_prog: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, an optional first-word-fall-through read port, and sticky
// overflow/underflow error flags.
//
// Ports:
//   clk          - clock; all state changes on the rising edge
//   rst          - synchronous active-high reset
//   data_in      - write data (WIDTH bits)
//   enq          - write request, accepted when not full
//   wrfull       - occupancy == DEPTH
//   almost_full  - occupancy >= AF_LEVEL
//   data_out     - read data (registered when FWFT=0, head-of-queue when FWFT=1)
//   deq          - read request, accepted when not empty
//   rdempty      - occupancy == 0
//   almost_empty - occupancy <= AE_LEVEL
//   count        - current occupancy, 0..DEPTH
//   overflow     - sticky: enq seen while full
//   underflow    - sticky: deq seen while empty
//   clr_err      - clears overflow/underflow (a same-cycle set wins)
module fifo_prog #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     enq,
  output logic                     wrfull,
  output logic                     almost_full,
  output logic [WIDTH-1:0]         data_out,
  input  logic                     deq,
  output logic                     rdempty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc;
  logic             rd_acc;
  logic             full;
  logic             empty;

  // Status flags depend only on the count register.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == CW'(0));
  assign wrfull       = full;
  assign rdempty      = empty;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Next-state: accept/reject requests, advance pointers, track occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_acc  = enq && !full;
    rd_acc  = deq && !empty;

    if (wr_acc) wptr_d = wptr_q + PW'(1);
    if (rd_acc) rptr_d = rptr_q + PW'(1);

    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);

    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    // Sets override a same-cycle clear. A deq paired with an accepted write
    // on an empty FIFO is treated as a pass-through, not an underflow.
    if (enq && full)                        ovf_d = 1'b1;
    if (deq && empty && !wr_acc)            unf_d = 1'b1;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wptr_q] <= data_in;
  end

  // Read port: registered on accepted read, or head-of-queue in FWFT mode.
  if (FWFT == 0) begin : g_reg_read
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_acc) dout_d = mem_q[rptr_q];
    end

    always_ff @(posedge clk) begin
      if (rst) dout_q <= '0;
      else     dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end else begin : g_fwft_read
    assign data_out = mem_q[rptr_q];
  end

endmodule

// File: tb/tb_fifo_prog.sv
// Self-checking bench for fifo_prog: a reference model with a data queue runs
// alongside a registered-read instance; a second FWFT instance gets a short
// directed sequence.
module tb_fifo_prog;

  logic       clk;
  logic       rst;
  logic [3:0] data_in;
  logic       enq;
  logic       deq;
  logic       clr_err;
  logic       wrfull;
  logic       almost_full;
  logic [3:0] data_out;
  logic       rdempty;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  logic       f_rst;
  logic [3:0] f_data_in;
  logic       f_enq;
  logic       f_deq;
  logic       f_clr_err;
  logic       f_wrfull;
  logic       f_almost_full;
  logic [3:0] f_data_out;
  logic       f_rdempty;
  logic       f_almost_empty;
  logic [2:0] f_count;
  logic       f_overflow;
  logic       f_underflow;

  int n_checks;
  int n_errors;

  // Reference model state
  logic [3:0] sb[$];
  int         m_count;
  logic       m_ovf;
  logic       m_unf;
  logic [3:0] m_dout;

  fifo_prog #(.WIDTH(4), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .enq(enq), .wrfull(wrfull),
    .almost_full(almost_full), .data_out(data_out), .deq(deq),
    .rdempty(rdempty), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  fifo_prog #(.WIDTH(4), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut_f (
    .clk(clk), .rst(f_rst), .data_in(f_data_in), .enq(f_enq), .wrfull(f_wrfull),
    .almost_full(f_almost_full), .data_out(f_data_out), .deq(f_deq),
    .rdempty(f_rdempty), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow), .clr_err(f_clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit rd);
    chk({tag, " count"}, 32'(count), 32'(m_count));
    chk({tag, " rdempty"}, 32'(rdempty), 32'(m_count == 0));
    chk({tag, " wrfull"}, 32'(wrfull), 32'(m_count == 4));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(m_count >= 3));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(m_count <= 1));
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(m_unf));
    if (rd) chk({tag, " data_out"}, 32'(data_out), 32'(m_dout));
    else    chk({tag, " data_out hold"}, 32'(data_out), 32'(m_dout));
  endtask

  // One clock on the registered-read instance, with model update and checks.
  task automatic step(input string tag, input bit e, input bit d,
                      input logic [3:0] din, input bit c, input bit r);
    bit wr, rd, full, empty;
    rst = r; enq = e; deq = d; data_in = din; clr_err = c;
    @(posedge clk);
    #1;
    full  = (m_count == 4);
    empty = (m_count == 0);
    wr = e && !full;
    rd = d && !empty;
    if (r) begin
      sb.delete();
      m_count = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dout = 4'h0;
      rd = 1'b0;
    end else begin
      if (rd) m_dout = sb.pop_front();
      if (wr) sb.push_back(din);
      if (wr && !rd) m_count++;
      else if (rd && !wr) m_count--;
      if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (e && full) m_ovf = 1'b1;
      if (d && empty && !wr) m_unf = 1'b1;
    end
    rst = 1'b0; enq = 1'b0; deq = 1'b0; clr_err = 1'b0;
    check_all(tag, rd);
  endtask

  task automatic fstep(input bit e, input bit d, input logic [3:0] din, input bit r);
    f_rst = r; f_enq = e; f_deq = d; f_data_in = din;
    @(posedge clk);
    #1;
    f_rst = 1'b0; f_enq = 1'b0; f_deq = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_count = 0; m_ovf = 1'b0; m_unf = 1'b0; m_dout = 4'h0;
    rst = 1'b1; enq = 1'b0; deq = 1'b0; data_in = 4'h0; clr_err = 1'b0;
    f_rst = 1'b1; f_enq = 1'b0; f_deq = 1'b0; f_data_in = 4'h0; f_clr_err = 1'b0;

    // Reset overrides simultaneous requests
    step("reset", 1'b1, 1'b1, 4'hF, 1'b1, 1'b1);

    // Single write then read
    step("enq8", 1'b1, 1'b0, 4'h8, 1'b0, 1'b0);
    step("deq8", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);

    // Fill, overflow, drain in order
    step("fill6", 1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
    step("fill7", 1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
    step("fill3", 1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    step("fill5", 1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
    step("ovf9",  1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    step("clr_ovf", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Underflow set, clear, and set beating clear
    step("unf", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    step("clr_unf", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step("clr_vs_set", 1'b0, 1'b1, 4'h0, 1'b1, 1'b0);
    step("clr2", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Simultaneous enq/deq when full and when empty
    for (int i = 1; i <= 4; i++) step("fill", 1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
    step("full_both", 1'b1, 1'b1, 4'hE, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("drain2", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    step("clr3", 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step("empty_both", 1'b1, 1'b1, 4'hC, 1'b0, 1'b0);
    step("deqC", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);

    // Streaming pairs wrap the pointers several times
    for (int i = 0; i < 10; i++)
      step("stream", 1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    step("stream_last", 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);

    // Reset mid-burst
    step("pre_rst_a", 1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    step("pre_rst_b", 1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
    step("mid_rst", 1'b1, 1'b0, 4'h3, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 80; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0), 1'b0);

    // FWFT instance: head word visible without deq; reset with count 2
    fstep(1'b0, 1'b0, 4'h0, 1'b1);
    chk("fwft rst rdempty", 32'(f_rdempty), 32'd1);
    fstep(1'b1, 1'b0, 4'hA, 1'b0);
    chk("fwft rdempty fall", 32'(f_rdempty), 32'd0);
    chk("fwft data_out A", 32'(f_data_out), 32'hA);
    fstep(1'b1, 1'b0, 4'h3, 1'b0);
    chk("fwft count 2", 32'(f_count), 32'd2);
    chk("fwft head held", 32'(f_data_out), 32'hA);
    fstep(1'b0, 1'b1, 4'h0, 1'b0);
    chk("fwft next head", 32'(f_data_out), 32'h3);
    fstep(1'b1, 1'b0, 4'h5, 1'b0);
    chk("fwft count 2b", 32'(f_count), 32'd2);
    fstep(1'b1, 1'b1, 4'h7, 1'b1);
    chk("fwft rst count", 32'(f_count), 32'd0);
    chk("fwft rst rdempty", 32'(f_rdempty), 32'd1);
    chk("fwft rst ovf", 32'(f_overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
